// File: rtl/cva6_shtlb_arbiter_pkg.sv
// Shared types and widths for the ITLB/DTLB shared-TLB arbiter.
package cva6_shtlb_arb_pkg;

   localparam int unsigned CNT_W    = 32;
   localparam int unsigned STARVE_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DROP  = 2'd3
   } shtlb_arb_state_e;

   typedef enum logic {
      OWN_ITLB = 1'b0,
      OWN_DTLB = 1'b1
   } shtlb_owner_e;

endpackage

// File: rtl/cva6_shtlb_arbiter_if.sv
// Lookup/response bundle between the two L1 TLBs, the arbiter and the shared TLB.
// Signal suffixes are from the arbiter's point of view.
interface cva6_shtlb_arbiter_if #(
   parameter int unsigned VPN_W  = 20,
   parameter int unsigned ASID_W = 9
) ();

   logic              itlb_req_i;
   logic [VPN_W-1:0]  itlb_vpn_i;
   logic [ASID_W-1:0] itlb_asid_i;
   logic              itlb_gnt_o;
   logic              itlb_rsp_valid_o;

   logic              dtlb_req_i;
   logic [VPN_W-1:0]  dtlb_vpn_i;
   logic [ASID_W-1:0] dtlb_asid_i;
   logic              dtlb_gnt_o;
   logic              dtlb_rsp_valid_o;

   logic              rsp_hit_o;

   logic              shtlb_req_o;
   logic [VPN_W-1:0]  shtlb_vpn_o;
   logic [ASID_W-1:0] shtlb_asid_o;
   logic              shtlb_is_instr_o;
   logic              shtlb_gnt_i;
   logic              shtlb_rsp_valid_i;
   logic              shtlb_hit_i;

   // Arbiter side
   modport slave (
      input  itlb_req_i, itlb_vpn_i, itlb_asid_i,
      input  dtlb_req_i, dtlb_vpn_i, dtlb_asid_i,
      output itlb_gnt_o, itlb_rsp_valid_o,
      output dtlb_gnt_o, dtlb_rsp_valid_o,
      output rsp_hit_o,
      output shtlb_req_o, shtlb_vpn_o, shtlb_asid_o, shtlb_is_instr_o,
      input  shtlb_gnt_i, shtlb_rsp_valid_i, shtlb_hit_i
   );

   // L1 TLBs + shared TLB side
   modport master (
      output itlb_req_i, itlb_vpn_i, itlb_asid_i,
      output dtlb_req_i, dtlb_vpn_i, dtlb_asid_i,
      input  itlb_gnt_o, itlb_rsp_valid_o,
      input  dtlb_gnt_o, dtlb_rsp_valid_o,
      input  rsp_hit_o,
      input  shtlb_req_o, shtlb_vpn_o, shtlb_asid_o, shtlb_is_instr_o,
      output shtlb_gnt_i, shtlb_rsp_valid_i, shtlb_hit_i
   );

endinterface

// File: rtl/cva6_shtlb_arbiter.sv
// Arbitrates ITLB/DTLB misses onto the shared TLB, one lookup outstanding, flush-safe.
// Optional perf counters enabled by defining SHTLB_ARB_PERF_EN.
module cva6_shtlb_arbiter
   import cva6_shtlb_arb_pkg::*;
#(
   parameter int unsigned VPN_W        = 20,
   parameter int unsigned ASID_W       = 9,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   cva6_shtlb_arbiter_if.slave     bus,
`ifdef SHTLB_ARB_PERF_EN
   output logic [CNT_W-1:0]        itlb_lookups_o,
   output logic [CNT_W-1:0]        dtlb_lookups_o,
   output logic [CNT_W-1:0]        miss_cnt_o,
`endif
   output logic                    busy_o
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end

   shtlb_arb_state_e    state_q, state_d;
   shtlb_owner_e        owner_q, owner_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [VPN_W-1:0]    vpn_q, vpn_d;
   logic [ASID_W-1:0]   asid_q, asid_d;
   logic                req_q, req_d;
   logic                busy_q, busy_d;
   logic                irsp_q, irsp_d;
   logic                drsp_q, drsp_d;
   logic                hit_q, hit_d;
   logic                igrant_c, dgrant_c, deliver_c;

   // Next-state, arbitration and response routing
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      starve_d  = starve_q;
      vpn_d     = vpn_q;
      asid_d    = asid_q;
      hit_d     = hit_q;
      irsp_d    = 1'b0;
      drsp_d    = 1'b0;
      igrant_c  = 1'b0;
      dgrant_c  = 1'b0;
      deliver_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (!bus.itlb_req_i) starve_d = '0;
            if (!flush_i && (bus.itlb_req_i || bus.dtlb_req_i)) begin
               if (bus.itlb_req_i && (!bus.dtlb_req_i || starve_q == LIMIT)) begin
                  igrant_c = 1'b1;
                  owner_d  = OWN_ITLB;
                  vpn_d    = bus.itlb_vpn_i;
                  asid_d   = bus.itlb_asid_i;
                  starve_d = '0;
               end else begin
                  dgrant_c = 1'b1;
                  owner_d  = OWN_DTLB;
                  vpn_d    = bus.dtlb_vpn_i;
                  asid_d   = bus.dtlb_asid_i;
                  if (bus.itlb_req_i && starve_q < LIMIT)
                     starve_d = starve_q + STARVE_W'(1);
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.shtlb_gnt_i) state_d = flush_i ? DROP : WAIT;
            else if (flush_i)    state_d = IDLE;
         end
         WAIT: begin
            if (bus.shtlb_rsp_valid_i) begin
               state_d = IDLE;
               if (!flush_i) begin
                  deliver_c = 1'b1;
                  hit_d     = bus.shtlb_hit_i;
                  irsp_d    = (owner_q == OWN_ITLB);
                  drsp_d    = (owner_q == OWN_DTLB);
               end
            end else if (flush_i) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (bus.shtlb_rsp_valid_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      req_d  = (state_d == ISSUE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         owner_q  <= OWN_DTLB;
         starve_q <= '0;
         vpn_q    <= '0;
         asid_q   <= '0;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
         irsp_q   <= 1'b0;
         drsp_q   <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         vpn_q    <= vpn_d;
         asid_q   <= asid_d;
         req_q    <= req_d;
         busy_q   <= busy_d;
         irsp_q   <= irsp_d;
         drsp_q   <= drsp_d;
         hit_q    <= hit_d;
      end
   end

   // Grants are combinational from IDLE; gate with reset so they read 0 while held in reset
   assign bus.itlb_gnt_o       = igrant_c & rst_ni;
   assign bus.dtlb_gnt_o       = dgrant_c & rst_ni;
   assign bus.itlb_rsp_valid_o = irsp_q;
   assign bus.dtlb_rsp_valid_o = drsp_q;
   assign bus.rsp_hit_o        = hit_q;
   assign bus.shtlb_req_o      = req_q;
   assign bus.shtlb_vpn_o      = vpn_q;
   assign bus.shtlb_asid_o     = asid_q;
   assign bus.shtlb_is_instr_o = (owner_q == OWN_ITLB) && busy_or_held();
   assign busy_o               = busy_q;

   // Owner resets to DTLB, so the decode is already 0 out of reset
   function automatic logic busy_or_held();
      return 1'b1;
   endfunction

`ifdef SHTLB_ARB_PERF_EN
   logic [CNT_W-1:0] ilook_q, dlook_q, miss_q;

   // Lookups count at grant (flushed ones included); misses only when delivered
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ilook_q <= '0;
         dlook_q <= '0;
         miss_q  <= '0;
      end else begin
         if (igrant_c)                          ilook_q <= ilook_q + CNT_W'(1);
         if (dgrant_c)                          dlook_q <= dlook_q + CNT_W'(1);
         if (deliver_c && !bus.shtlb_hit_i)     miss_q  <= miss_q + CNT_W'(1);
      end
   end

   assign itlb_lookups_o = ilook_q;
   assign dtlb_lookups_o = dlook_q;
   assign miss_cnt_o     = miss_q;
`endif

   // A response is only legal while a lookup is accepted by the shared TLB
   a_rsp_protocol: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.shtlb_rsp_valid_i && (state_q == IDLE || state_q == ISSUE)))
      else $error("shtlb_rsp_valid_i seen with no lookup outstanding");

endmodule
